// File: rtl/png_pkg.sv
// Shared definitions for the PNG output buffer: FSM states, CRC polynomial and
// file-length width, plus the 4-bytes-per-cycle CRC32 step.
package png_pkg;

  typedef enum logic [1:0] {
    PNG_OB_IDLE,
    PNG_OB_RUN,
    PNG_OB_FLUSH,
    PNG_OB_DRAIN
  } png_ob_state_e;

  localparam logic [31:0] PNG_CRC_POLY = 32'hEDB88320;
  localparam int          PNG_LEN_W    = 23;
  localparam int          PNG_CNT_W    = 21;

  // Reflected CRC32 over one stream word; byte [31:24] goes first on the wire.
  function automatic logic [31:0] png_crc32_word(input logic [31:0] crc,
                                                 input logic [31:0] w);
    logic [31:0] c;
    c = crc;
    for (int b = 3; b >= 0; b--) begin
      c = c ^ {24'd0, w[b*8 +: 8]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ PNG_CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/png_out_buf_if.sv
// Encoder-side stream and sink-side ready/valid port of the PNG output buffer.
interface png_out_buf_if;
  import png_pkg::*;

  logic                 frame_start;
  logic                 frame_end;
  logic [PNG_LEN_W-1:0] png_file_len;
  logic                 cdata_vld;
  logic [31:0]          cdata;
  logic                 out_valid;
  logic [31:0]          out_data;
  logic                 out_last;
  logic                 out_ready;

  modport slave (
    input  frame_start, frame_end, png_file_len, cdata_vld, cdata, out_ready,
    output out_valid, out_data, out_last
  );

  modport master (
    output frame_start, frame_end, png_file_len, cdata_vld, cdata, out_ready,
    input  out_valid, out_data, out_last
  );
endinterface

// File: rtl/png_out_fifo.sv
// First-word-fall-through FIFO, DEPTH x 33 (last tag + data), with occupancy.
module png_out_fifo #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [32:0]   wdata,
  input  logic          pop,
  output logic [32:0]   rdata,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);

  logic [32:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        wr_en, rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign rdata = empty ? 33'd0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/png_out_buf.sv
// PNG encoder output buffer: hold register tags the final word, FIFO decouples
// the sink, word count is checked against the file length.
// Optional stream CRC32 is built when PNG_OUT_CRC_EN is defined.
module png_out_buf
  import png_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  png_out_buf_if.slave         bus,
  output logic [AW:0]          fifo_level,
  output logic [PNG_CNT_W-1:0] word_cnt,
  output logic                 overflow,
  output logic                 len_err,
  output logic                 busy,
  output logic [31:0]          crc_out
);

  localparam logic [PNG_CNT_W-1:0] CNT_MAX = '1;

  png_ob_state_e         state_q, state_d;
  logic [31:0]           hold_q, hold_d;
  logic                  hold_v_q, hold_v_d;
  logic [PNG_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  len_err_q, len_err_d;

  logic                  push, pop, empty, full;
  logic [32:0]           push_data, head;
  logic [PNG_LEN_W:0]    exp_words;

  assign pop       = !empty && bus.out_ready;
  assign exp_words = ({1'b0, bus.png_file_len} + 24'd3) >> 2;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    hold_v_d  = hold_v_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    len_err_d = len_err_q;
    push      = 1'b0;
    push_data = '0;
    case (state_q)
      PNG_OB_IDLE: begin
        if (bus.frame_start) begin
          state_d   = PNG_OB_RUN;
          hold_v_d  = 1'b0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          len_err_d = 1'b0;
        end
      end
      PNG_OB_RUN: begin
        if (bus.cdata_vld) begin
          if (hold_v_q) begin
            push      = 1'b1;
            push_data = {1'b0, hold_q};
            if (full && !pop) ovf_d = 1'b1;
          end
          hold_d   = bus.cdata;
          hold_v_d = 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
        // cnt_d already includes a word arriving alongside frame_end
        if (bus.frame_end) begin
          state_d   = PNG_OB_FLUSH;
          len_err_d = ({3'd0, cnt_d} != exp_words);
        end
      end
      PNG_OB_FLUSH: begin
        if (!hold_v_q) begin
          state_d = PNG_OB_DRAIN;
        end else if (!full || pop) begin
          push      = 1'b1;
          push_data = {1'b1, hold_q};
          hold_v_d  = 1'b0;
          state_d   = PNG_OB_DRAIN;
        end
      end
      PNG_OB_DRAIN: begin
        if (empty) state_d = PNG_OB_IDLE;
      end
      default: state_d = PNG_OB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PNG_OB_IDLE;
      hold_q    <= '0;
      hold_v_q  <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      hold_v_q  <= hold_v_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      len_err_q <= len_err_d;
    end
  end

  png_out_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (head),
    .empty (empty),
    .full  (full),
    .level (fifo_level)
  );

  assign bus.out_valid = !empty;
  assign bus.out_data  = head[31:0];
  assign bus.out_last  = head[32];
  assign word_cnt      = cnt_q;
  assign overflow      = ovf_q;
  assign len_err       = len_err_q;
  assign busy          = (state_q != PNG_OB_IDLE);

`ifdef PNG_OUT_CRC_EN
  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (state_q == PNG_OB_IDLE && bus.frame_start)
      crc_d = '1;
    else if (state_q == PNG_OB_RUN && bus.cdata_vld)
      crc_d = png_crc32_word(crc_q, bus.cdata);
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= '1;
    else     crc_q <= crc_d;
  end

  assign crc_out = ~crc_q;
`else
  assign crc_out = '0;
`endif

endmodule

// File: tb/tb_png_out_buf.sv
// Directed bench for png_out_buf with a 4-deep FIFO: per-cycle vector table for
// a basic frame, then hand sequences for length, overflow, backpressure, reset.
module tb_png_out_buf;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [AW:0] fifo_level;
  logic [20:0] word_cnt;
  logic        overflow, len_err, busy;
  logic [31:0] crc_out;

  png_out_buf_if bus ();

  png_out_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fifo_level (fifo_level),
    .word_cnt   (word_cnt),
    .overflow   (overflow),
    .len_err    (len_err),
    .busy       (busy),
    .crc_out    (crc_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit tog    = 1'b0;

  // Sink monitor: records accepted words and watches held data under stall.
  logic [32:0] q[$];
  int          stab_n = 0, stab_viol = 0;
  logic        pv = 1'b0;
  logic [32:0] pd = '0;

  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv) begin
        stab_n++;
        if (!bus.out_valid || {bus.out_last, bus.out_data} !== pd) stab_viol++;
      end
      pv = bus.out_valid && !bus.out_ready;
      pd = {bus.out_last, bus.out_data};
      if (bus.out_valid && bus.out_ready) q.push_back({bus.out_last, bus.out_data});
    end
  end

  typedef struct {
    logic        fs, fe;
    logic [22:0] len;
    logic        vld;
    logic [31:0] d;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic [2:0]  elvl;
    logic        eb;
  } vec_t;

  vec_t tbl[9];

  task automatic cyc();
    @(posedge clk);
    #1;
    if (tog) bus.out_ready = ~bus.out_ready;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_frame(input int n, input logic [22:0] len,
                           input logic [31:0] base, input int gap);
    bus.frame_start = 1'b1;
    cyc();
    bus.frame_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.cdata_vld = 1'b1;
      bus.cdata     = base + i;
      if (i == n - 1) begin
        bus.frame_end    = 1'b1;
        bus.png_file_len = len;
      end
      cyc();
      bus.cdata_vld = 1'b0;
      bus.frame_end = 1'b0;
      for (int g = 0; g < gap; g++) cyc();
    end
    if (n == 0) begin
      bus.frame_end    = 1'b1;
      bus.png_file_len = len;
      cyc();
      bus.frame_end = 1'b0;
    end
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 300) begin
      cyc();
      k++;
    end
    chk({nm, " drain busy"}, busy, 0);
  endtask

  task automatic check_q(input string nm, input int from, input logic [32:0] e[$]);
    chk({nm, " word count"}, q.size() - from, e.size());
    for (int i = 0; i < e.size() && from + i < q.size(); i++)
      chk({nm, " word"}, q[from+i], e[i]);
  endtask

  initial begin
    logic [32:0] e[$];
    int          base;

    rst              = 1'b1;
    bus.frame_start  = 1'b0;
    bus.frame_end    = 1'b0;
    bus.png_file_len = '0;
    bus.cdata_vld    = 1'b0;
    bus.cdata        = '0;
    bus.out_ready    = 1'b1;
    cyc();
    cyc();
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst out_data", bus.out_data, 0);
    chk("rst out_last", bus.out_last, 0);
    chk("rst level", fifo_level, 0);
    chk("rst word_cnt", word_cnt, 0);
    chk("rst overflow", overflow, 0);
    chk("rst len_err", len_err, 0);
    chk("rst busy", busy, 0);
    chk("rst crc_out", crc_out, 0);
    rst = 1'b0;
    cyc();

    // Basic frame, out_ready=1: row inputs apply for one cycle, outputs checked after the edge.
    //            fs  fe  len    vld d             ev  ed            el  lvl eb
    tbl[0] = '{1'b1, 1'b0, 23'd0,  1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 3'd0, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 23'd0,  1'b1, 32'h89504E47, 1'b0, 32'h0,        1'b0, 3'd0, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 23'd0,  1'b1, 32'h0D0A1A0A, 1'b1, 32'h89504E47, 1'b0, 3'd1, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 23'd0,  1'b1, 32'h0000000D, 1'b1, 32'h0D0A1A0A, 1'b0, 3'd1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 23'd0,  1'b1, 32'h49484452, 1'b1, 32'h0000000D, 1'b0, 3'd1, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 23'd20, 1'b1, 32'h00000004, 1'b1, 32'h49484452, 1'b0, 3'd1, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 23'd0,  1'b0, 32'h0,        1'b1, 32'h00000004, 1'b1, 3'd1, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 23'd0,  1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 3'd0, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 23'd0,  1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 3'd0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      bus.frame_start = tbl[i].fs;
      bus.frame_end   = tbl[i].fe;
      if (tbl[i].fe) bus.png_file_len = tbl[i].len;
      bus.cdata_vld   = tbl[i].vld;
      bus.cdata       = tbl[i].d;
      cyc();
      chk($sformatf("basic[%0d] out_valid", i), bus.out_valid, tbl[i].ev);
      chk($sformatf("basic[%0d] out_data", i), bus.out_data, tbl[i].ed);
      chk($sformatf("basic[%0d] out_last", i), bus.out_last, tbl[i].el);
      chk($sformatf("basic[%0d] level", i), fifo_level, tbl[i].elvl);
      chk($sformatf("basic[%0d] busy", i), busy, tbl[i].eb);
    end
    chk("basic word_cnt", word_cnt, 5);
    chk("basic len_err", len_err, 0);
    chk("basic overflow", overflow, 0);

    // Length check: 3 words against several file lengths.
    run_frame(3, 23'd12, 32'h10, 0);
    wait_idle("len12");
    chk("len12 word_cnt", word_cnt, 3);
    chk("len12 len_err", len_err, 0);
    run_frame(3, 23'd9, 32'h20, 0);
    wait_idle("len9");
    chk("len9 len_err", len_err, 0);
    run_frame(3, 23'd13, 32'h30, 0);
    wait_idle("len13");
    chk("len13 len_err", len_err, 1);
    run_frame(3, 23'd16, 32'h40, 0);
    wait_idle("len16");
    chk("len16 word_cnt", word_cnt, 3);
    chk("len16 len_err", len_err, 1);

    // Empty frame: nothing emitted, zero length matches zero words.
    base = q.size();
    run_frame(0, 23'd0, 32'h0, 0);
    wait_idle("empty");
    chk("empty words out", q.size() - base, 0);
    chk("empty word_cnt", word_cnt, 0);
    chk("empty len_err", len_err, 0);

    // Overflow: sink stalled, 7 words into 4 entries + hold.
    bus.out_ready = 1'b0;
    base = q.size();
    run_frame(7, 23'd28, 32'hA0, 0);
    chk("ovf level", fifo_level, 4);
    chk("ovf overflow", overflow, 1);
    chk("ovf word_cnt", word_cnt, 7);
    chk("ovf head", bus.out_data, 32'hA0);
    chk("ovf busy", busy, 1);
    bus.out_ready = 1'b1;
    wait_idle("ovf");
    e = {};
    for (int i = 0; i < 4; i++) e.push_back({1'b0, 32'hA0 + i});
    e.push_back({1'b1, 32'hA6});
    check_q("ovf", base, e);
    chk("ovf len_err", len_err, 0);

    // Backpressure: out_ready toggles every cycle, one word every third cycle.
    base = q.size();
    tog = 1'b1;
    run_frame(10, 23'd40, 32'hB0, 2);
    wait_idle("bp");
    tog = 1'b0;
    bus.out_ready = 1'b1;
    e = {};
    for (int i = 0; i < 10; i++) e.push_back({(i == 9), 32'hB0 + i});
    check_q("bp", base, e);
    chk("bp overflow", overflow, 0);
    chk("stall cycles seen", (stab_n > 0), 1);
    chk("stall data stable", stab_viol, 0);

    // Reset in the middle of a frame with words queued.
    bus.out_ready   = 1'b0;
    bus.frame_start = 1'b1;
    cyc();
    bus.frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.cdata_vld = 1'b1;
      bus.cdata     = 32'hD0 + i;
      cyc();
    end
    bus.cdata_vld = 1'b0;
    chk("pre-rst level", fifo_level, 2);
    rst = 1'b1;
    cyc();
    chk("midrst out_valid", bus.out_valid, 0);
    chk("midrst out_data", bus.out_data, 0);
    chk("midrst out_last", bus.out_last, 0);
    chk("midrst level", fifo_level, 0);
    chk("midrst word_cnt", word_cnt, 0);
    chk("midrst busy", busy, 0);
    chk("midrst len_err", len_err, 0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    base = q.size();
    run_frame(2, 23'd8, 32'hC0, 0);
    wait_idle("postrst");
    e = {};
    e.push_back({1'b0, 32'hC0});
    e.push_back({1'b1, 32'hC1});
    check_q("postrst", base, e);
    chk("postrst len_err", len_err, 0);

    // CRC over "IEND".
    run_frame(1, 23'd4, 32'h49454E44, 0);
    wait_idle("crc");
    chk("crc len_err", len_err, 0);
`ifdef PNG_OUT_CRC_EN
    chk("crc_out IEND", crc_out, 32'hAE426082);
`else
    chk("crc_out tied", crc_out, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
